// File: rtl/vga_framebuffer_reader_pkg.sv
// Shared VGA timing defaults and pixel encoding for the framebuffer reader.
package vga_framebuffer_reader_pkg;

   localparam int H_ACTIVE_DEF = 640;
   localparam int H_FP_DEF     = 16;
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BP_DEF     = 48;
   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FP_DEF     = 10;
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BP_DEF     = 33;
   localparam int ADDR_W_DEF   = 19;
   localparam int COUNT_W      = 10;

   typedef logic [COUNT_W-1:0] count_t;

   typedef struct packed {
      logic red;
      logic green;
      logic blue;
   } rgb_t;

   localparam rgb_t RGB_BLACK = '{red: 1'b0, green: 1'b0, blue: 1'b0};

   function automatic count_t toCount(input int value);
      return count_t'(value);
   endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// Raster H/V counters advanced on the pixel enable, with decoded region flags.
module vga_timing_counter
   import vga_framebuffer_reader_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int H_FP     = H_FP_DEF,
   parameter int H_SYNC   = H_SYNC_DEF,
   parameter int H_BP     = H_BP_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int V_FP     = V_FP_DEF,
   parameter int V_SYNC   = V_SYNC_DEF,
   parameter int V_BP     = V_BP_DEF
) (
   input  logic   Clock,
   input  logic   Reset,
   input  logic   pixelEn,
   output count_t hCount,
   output count_t vCount,
   output logic   active,
   output logic   hSyncRaw,
   output logic   vSyncRaw,
   output logic   vWrap,
   output logic   lastActive,
   output logic   vBlank
);

   localparam count_t H_ACT        = toCount(H_ACTIVE);
   localparam count_t H_ACT_LAST   = toCount(H_ACTIVE - 1);
   localparam count_t H_SYNC_BEGIN = toCount(H_ACTIVE + H_FP);
   localparam count_t H_SYNC_END   = toCount(H_ACTIVE + H_FP + H_SYNC);
   localparam count_t H_LAST       = toCount(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam count_t V_ACT        = toCount(V_ACTIVE);
   localparam count_t V_ACT_LAST   = toCount(V_ACTIVE - 1);
   localparam count_t V_SYNC_BEGIN = toCount(V_ACTIVE + V_FP);
   localparam count_t V_SYNC_END   = toCount(V_ACTIVE + V_FP + V_SYNC);
   localparam count_t V_LAST       = toCount(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

   logic hWrap;

   assign hWrap      = (hCount == H_LAST);
   assign vWrap      = hWrap && (vCount == V_LAST);
   assign active     = (hCount < H_ACT) && (vCount < V_ACT);
   assign vBlank     = (vCount >= V_ACT);
   assign lastActive = (hCount == H_ACT_LAST) && (vCount == V_ACT_LAST);
   assign hSyncRaw   = (hCount >= H_SYNC_BEGIN) && (hCount < H_SYNC_END);
   assign vSyncRaw   = (vCount >= V_SYNC_BEGIN) && (vCount < V_SYNC_END);

   always_ff @(posedge Clock) begin
      if (Reset) begin
         hCount <= '0;
         vCount <= '0;
      end else if (pixelEn) begin
         if (hWrap) begin
            hCount <= '0;
            vCount <= vWrap ? '0 : vCount + count_t'(1);
         end else begin
            hCount <= hCount + count_t'(1);
         end
      end
   end

endmodule

// File: rtl/vga_framebuffer_reader.sv
// Single-clock VGA reader: raster address walk over video RAM and aligned RGB/sync pins.
module vga_framebuffer_reader
   import vga_framebuffer_reader_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int H_FP     = H_FP_DEF,
   parameter int H_SYNC   = H_SYNC_DEF,
   parameter int H_BP     = H_BP_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int V_FP     = V_FP_DEF,
   parameter int V_SYNC   = V_SYNC_DEF,
   parameter int V_BP     = V_BP_DEF,
   parameter int ADDR_W   = ADDR_W_DEF
) (
   input  logic              Clock,
   input  logic              Reset,
   output logic [ADDR_W-1:0] oVideoReadAddress,
   input  logic [2:0]        iVideoData,
   output logic              oVGA_RED,
   output logic              oVGA_GREEN,
   output logic              oVGA_BLUE,
   output logic              oVGA_HSYNC,
   output logic              oVGA_VSYNC,
   output logic [9:0]        oHcounter,
   output logic [9:0]        oVcounter,
   output logic              oVBlank,
   output logic              oFrameStart
);

   logic   rPixelEn;
   count_t hCount;
   count_t vCount;
   logic   active;
   logic   hSyncRaw;
   logic   vSyncRaw;
   logic   vWrap;
   logic   lastActive;
   logic   vBlank;
   rgb_t   rgbQ;
   logic   hSyncQ;
   logic   vSyncQ;

   vga_timing_counter #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP)
   ) uTiming (
      .Clock      (Clock),
      .Reset      (Reset),
      .pixelEn    (rPixelEn),
      .hCount     (hCount),
      .vCount     (vCount),
      .active     (active),
      .hSyncRaw   (hSyncRaw),
      .vSyncRaw   (vSyncRaw),
      .vWrap      (vWrap),
      .lastActive (lastActive),
      .vBlank     (vBlank)
   );

   // The address leads the output stage by one pixel period; RAM data for the
   // current (h,v) arrives on the off edge in between, so pins lag counters by 2 Clocks.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         rPixelEn          <= 1'b0;
         oVideoReadAddress <= '0;
         rgbQ              <= RGB_BLACK;
         hSyncQ            <= 1'b1;
         vSyncQ            <= 1'b1;
         oFrameStart       <= 1'b0;
      end else begin
         rPixelEn    <= ~rPixelEn;
         oFrameStart <= rPixelEn && vWrap;
         if (rPixelEn) begin
            if (vWrap || lastActive) begin
               oVideoReadAddress <= '0;
            end else if (active) begin
               oVideoReadAddress <= oVideoReadAddress + ADDR_W'(1);
            end
            rgbQ   <= active ? rgb_t'(iVideoData) : RGB_BLACK;
            hSyncQ <= ~hSyncRaw;
            vSyncQ <= ~vSyncRaw;
         end
      end
   end

   assign oVGA_RED   = rgbQ.red;
   assign oVGA_GREEN = rgbQ.green;
   assign oVGA_BLUE  = rgbQ.blue;
   assign oVGA_HSYNC = hSyncQ;
   assign oVGA_VSYNC = vSyncQ;
   assign oHcounter  = hCount;
   assign oVcounter  = vCount;
   assign oVBlank    = vBlank;

endmodule

// File: doc/vga_framebuffer_reader.md
Name: vga_framebuffer_reader

Overview:
Reader end of the video-RAM path. The CPU side writes 3-bit RGB pixels into a 640x480 video RAM; this block generates VGA timing and walks the read addresses in raster order. It then drives RGB and sync pins with sync aligned to the pixel data. It sits between the video RAM read port and the board VGA pins, and replaces the standalone timing controller plus divided-clock scheme with a single-clock design that uses a pixel enable.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
ADDR_W, 19, video RAM address width (must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE)

Ports:
Clock  in  1  system clock, 50 MHz
Reset  in  1  synchronous, active-high reset
oVideoReadAddress  out  ADDR_W  read address to video RAM
iVideoData  in  3  {R,G,B} from video RAM; synchronous read, latency 1 Clock
oVGA_RED  out  1  red pin
oVGA_GREEN  out  1  green pin
oVGA_BLUE  out  1  blue pin
oVGA_HSYNC  out  1  horizontal sync, active-low
oVGA_VSYNC  out  1  vertical sync, active-low
oHcounter  out  10  current horizontal count
oVcounter  out  10  current vertical count
oVBlank  out  1  high while oVcounter >= V_ACTIVE
oFrameStart  out  1  one-Clock pulse when counters wrap to (0,0)

Behaviour:
- Reset values: rPixelEn=0, H=V=0, oVideoReadAddress=0, RGB=000, HSYNC=VSYNC=1, oFrameStart=0, oVBlank=0. Reset mid-frame takes effect on the next edge, with no partial-frame completion.
- Pixel enable: rPixelEn toggles every Clock. The counters, address, and output registers update only on edges where rPixelEn==1, so one pixel period is 2 Clocks. After Reset is released, the first counter advance occurs on the 2nd edge.
- H counts 0..H_TOTAL-1 (800) and wraps to 0. V increments on H wrap, counts 0..V_TOTAL-1 (525) and wraps to 0.
- Active region: H<H_ACTIVE and V<V_ACTIVE.
- Address generation uses an incrementer only, with no multiplier:
  - While the counters hold an active (h,v), oVideoReadAddress = v*H_ACTIVE+h.
  - Blanking holds the index of the next active pixel.
  - The address returns to 0 when V wraps.
  - The maximum value is 307199 at (639,479).
- Output stage, sampled on the pixel edge:
  - RGB <= active(h,v) ? iVideoData : 000.
  - HSYNC <= ~(H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC), i.e. low for h in 656..751.
  - VSYNC <= ~(V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC), i.e. low for v in 490..491.
- Latency: pins show pixel (h,v) exactly one pixel period (2 Clocks) after the counters show (h,v). RGB and syncs share the same pipeline depth, so they are always mutually aligned.
- The RAM read completes within the 2-Clock pixel period; a RAM latency greater than 1 Clock is unsupported.
- oFrameStart is high for the single Clock following the edge on which the counters become (0,0). It is never high during reset.
- oHcounter/oVcounter are the raw counter registers (un-delayed), for CPU-side polling.

Decomposition:
- Timing constants (H/V active, porches, sync, totals) and the RGB color encodings belong in the shared definitions include.
- One sub-module is natural: vga_timing_counter. It holds the H/V counters gated by the pixel enable, and outputs h, v, active, hsync_raw, vsync_raw and wrap flags. The address incrementer and output/alignment registers stay in vga_framebuffer_reader.

Test Plan:
1. Reset for 3 Clocks, then release → address=0, HSYNC=VSYNC=1, RGB=000; H reads 0 for 2 Clocks and then 1 on the 2nd edge after release.
2. Line timing → line period 1600 Clocks; HSYNC low for exactly 192 Clocks, with the falling edge 1314 Clocks (657 pixel periods) after H=0 is first seen.
3. Frame timing → frame = 525*1600 = 840000 Clocks; VSYNC low for exactly 3200 Clocks; exactly one oFrameStart pulse per frame; oVBlank high for 45 lines.
4. RAM model returning addr[2:0] with 1-Clock latency → RGB at pins for pixel (h,v) = (v*640+h)[2:0]; address 307199 seen at (639,479); address 0 after V wrap; RGB=000 for every blanking pixel.
5. Blanking address hold → for h=640..799 on line v<479, the address stays at (v+1)*640. During lines 480..524 the address stays 0 after wrap.
6. Reset asserted at H=300,V=100 for 1 Clock → the next edge shows all outputs at reset values; the next frame's timing restarts from (0,0) and matches test 2.
